// File: rtl/dma_priority_arbiter_if.sv
// Bus between the DMA arbiter and its requesters / CPU hold handshake.
// The master modport is the arbiter side; slave is the requester/CPU side.
interface dma_priority_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CHW    = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] dreq;
    logic [NUM_CH-1:0] sw_req;
    logic [NUM_CH-1:0] mask;
    logic              rotate_en;
    logic              dreq_low;
    logic              dack_low;
    logic              hlda;
    logic              xfer_done;
    logic              hrq;
    logic [NUM_CH-1:0] dack;
    logic              grant_valid;
    logic [CHW-1:0]    grant_ch;

    modport master (
        input  dreq, sw_req, mask, rotate_en, dreq_low, dack_low, hlda, xfer_done,
        output hrq, dack, grant_valid, grant_ch
    );

    modport slave (
        output dreq, sw_req, mask, rotate_en, dreq_low, dack_low, hlda, xfer_done,
        input  hrq, dack, grant_valid, grant_ch
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: registered requests, CPU hold handshake, fixed or
// rotating priority, one-hot acknowledge with selectable polarity.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CHW    = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    dma_priority_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

    state_t            state_reg, state_next;
    logic [NUM_CH-1:0] req_reg, req_next;
    logic [NUM_CH-1:0] grant_onehot_reg, grant_onehot_next;
    logic [CHW-1:0]    grant_ch_reg, grant_ch_next;
    logic [CHW-1:0]    ptr_reg, ptr_next;
    logic [CHW-1:0]    win_ch;
    logic              win_found;
    logic [CHW-1:0]    ptr_after_done;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_req
            assign req_next[gi] = !bus.mask[gi] &&
                                  ((bus.dreq[gi] ^ bus.dreq_low) || bus.sw_req[gi]);
        end
    endgenerate

    // Fixed priority is the rotating search with ptr pinned at 0.
    always_comb begin
        int             idx;
        logic [CHW-1:0] idx_c;
        win_ch    = '0;
        win_found = 1'b0;
        idx       = 0;
        idx_c     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_c = CHW'(idx);
            if (!win_found && req_reg[idx_c]) begin
                win_found = 1'b1;
                win_ch    = idx_c;
            end
        end
    end

    assign ptr_after_done = (grant_ch_reg == CHW'(NUM_CH - 1)) ? '0 : grant_ch_reg + 1'b1;

    always_comb begin
        state_next        = state_reg;
        grant_onehot_next = grant_onehot_reg;
        grant_ch_next     = grant_ch_reg;
        ptr_next          = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|req_reg) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                // Withdrawal wins over a simultaneous hlda.
                if (req_reg == '0) begin
                    state_next = IDLE;
                end else if (bus.hlda) begin
                    state_next        = GRANT;
                    grant_ch_next     = win_ch;
                    grant_onehot_next = NUM_CH'(1) << win_ch;
                end
            end
            GRANT: begin
                if (bus.xfer_done) begin
                    state_next        = IDLE;
                    grant_onehot_next = '0;
                    ptr_next          = ptr_after_done;
                end else if (!bus.hlda) begin
                    state_next        = IDLE;
                    grant_onehot_next = '0;
                end
            end
            default: begin
                state_next        = IDLE;
                grant_onehot_next = '0;
            end
        endcase
        if (!bus.rotate_en) begin
            ptr_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            req_reg          <= '0;
            grant_onehot_reg <= '0;
            grant_ch_reg     <= '0;
            ptr_reg          <= '0;
        end else begin
            state_reg        <= state_next;
            req_reg          <= req_next;
            grant_onehot_reg <= grant_onehot_next;
            grant_ch_reg     <= grant_ch_next;
            ptr_reg          <= ptr_next;
        end
    end

    assign bus.hrq         = (state_reg != IDLE);
    assign bus.grant_valid = (state_reg == GRANT);
    assign bus.grant_ch    = grant_ch_reg;
    assign bus.dack        = grant_onehot_reg ^ {NUM_CH{bus.dack_low}};
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_dma_priority_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dma_priority_arbiter_if #(.NUM_CH(N)) bus ();
    dma_priority_arbiter_if #(.NUM_CH(8)) bus8 ();

    dma_priority_arbiter #(.NUM_CH(N)) dut  (.clk(clk), .reset(reset), .bus(bus));
    dma_priority_arbiter #(.NUM_CH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (bus.grant_valid !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk({name, "_grant_seen"}, int'(bus.grant_valid), 1);
    endtask

    // Behavioural model: pending request set, hold-request flag, granted channel.
    int m_req = 0;
    int m_ptr = 0;
    int m_gnt = -1;
    bit m_ask = 1'b0;
    bit model_on = 1'b0;
    bit prev_gv = 1'b0;

    function automatic int pick(input int r, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (((r >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic int eff_req();
        int r;
        r = 0;
        for (int i = 0; i < N; i++)
            if (!bus.mask[i] && ((bus.dreq[i] ^ bus.dreq_low) || bus.sw_req[i])) r |= (1 << i);
        return r;
    endfunction

    always @(posedge clk) begin
        int nreq, ngnt, nptr;
        bit nask;
        nreq = eff_req();
        ngnt = m_gnt;
        nptr = m_ptr;
        nask = m_ask;
        if (reset) begin
            nreq = 0; ngnt = -1; nptr = 0; nask = 1'b0;
        end else begin
            if (m_gnt >= 0) begin
                if (bus.xfer_done) begin
                    nptr = (m_gnt + 1) % N;
                    ngnt = -1;
                end else if (!bus.hlda) begin
                    ngnt = -1;
                end
            end else if (m_ask) begin
                if (m_req == 0) nask = 1'b0;
                else if (bus.hlda) begin
                    ngnt = pick(m_req, m_ptr);
                    nask = 1'b0;
                end
            end else if (m_req != 0) begin
                nask = 1'b1;
            end
            if (!bus.rotate_en) nptr = 0;
        end
        m_req <= nreq;
        m_gnt <= ngnt;
        m_ptr <= nptr;
        m_ask <= nask;
    end

    always @(negedge clk) begin
        int exp_dack;
        if (model_on) begin
            exp_dack = ((m_gnt >= 0) ? (1 << m_gnt) : 0) ^ (bus.dack_low ? ((1 << N) - 1) : 0);
            chk("hrq", int'(bus.hrq), int'(m_ask || m_gnt >= 0));
            chk("grant_valid", int'(bus.grant_valid), int'(m_gnt >= 0));
            if (m_gnt >= 0) chk("grant_ch", int'(bus.grant_ch), m_gnt);
            chk("dack", int'(bus.dack), exp_dack);
            if (m_gnt >= 0 && !prev_gv) $display("grant ch %0d dack %b t=%0t", m_gnt, bus.dack, $time);
            prev_gv <= (m_gnt >= 0);
        end
    end

    initial begin
        bus.dreq = '0; bus.sw_req = '0; bus.mask = '0;
        bus.rotate_en = 1'b0; bus.dreq_low = 1'b0; bus.dack_low = 1'b0;
        bus.hlda = 1'b0; bus.xfer_done = 1'b0;
        bus8.dreq = '0; bus8.sw_req = 8'h80; bus8.mask = 8'h80;
        bus8.rotate_en = 1'b0; bus8.dreq_low = 1'b0; bus8.dack_low = 1'b0;
        bus8.hlda = 1'b0; bus8.xfer_done = 1'b0;
        reset = 1'b1;
        step(2);
        model_on = 1'b1;
        chk("rst_hrq", int'(bus.hrq), 0);
        chk("rst_gv", int'(bus.grant_valid), 0);
        chk("rst_gch", int'(bus.grant_ch), 0);
        chk("rst_dack", int'(bus.dack), 0);
        bus.dack_low = 1'b1;
        #1;
        chk("rst_dack_low", int'(bus.dack), 4'hF);
        bus.dack_low = 1'b0;
        reset = 1'b0;

        // Eight channels: masked software request never raises hrq.
        step(3);
        chk("ch8_masked_hrq", int'(bus8.hrq), 0);
        bus8.mask = 8'h00;
        step(1);
        chk("ch8_unmask_hrq_1", int'(bus8.hrq), 0);
        step(1);
        chk("ch8_unmask_hrq_2", int'(bus8.hrq), 1);
        bus8.sw_req = 8'h00;

        // Fixed priority, dreq 1010, hlda two cycles after hrq.
        bus.dreq = 4'b1010;
        step(1);
        chk("fix_hrq_lat", int'(bus.hrq), 0);
        step(1);
        chk("fix_hrq", int'(bus.hrq), 1);
        step(1);
        chk("fix_no_grant", int'(bus.grant_valid), 0);
        bus.hlda = 1'b1;
        step(1);
        chk("fix_gv", int'(bus.grant_valid), 1);
        chk("fix_gch", int'(bus.grant_ch), 1);
        chk("fix_dack", int'(bus.dack), 4'b0010);
        bus.xfer_done = 1'b1;
        bus.dreq = 4'b1000;
        step(1);
        bus.xfer_done = 1'b0;
        chk("fix_hrq_gap", int'(bus.hrq), 0);
        step(1);
        chk("fix_rereq_hrq", int'(bus.hrq), 1);
        step(1);
        chk("fix_gch3", int'(bus.grant_ch), 3);
        chk("fix_dack3", int'(bus.dack), 4'b1000);
        bus.dreq = 4'b0000;
        bus.xfer_done = 1'b1;
        step(1);
        bus.xfer_done = 1'b0;
        bus.hlda = 1'b0;
        step(2);

        // Rotating priority, all channels requesting.
        bus.rotate_en = 1'b1;
        bus.dreq = 4'b1111;
        bus.hlda = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_grant("rot");
            chk($sformatf("rot_order_%0d", i), int'(bus.grant_ch), i % N);
            bus.xfer_done = 1'b1;
            if (i == 4) begin
                bus.dreq = 4'b0000;
                bus.hlda = 1'b0;
            end
            step(1);
            bus.xfer_done = 1'b0;
        end
        step(2);

        // Active-low request and acknowledge polarity.
        bus.dreq_low = 1'b1;
        bus.dack_low = 1'b1;
        bus.dreq = 4'b1011;
        #1;
        chk("pol_dack_idle", int'(bus.dack), 4'hF);
        bus.hlda = 1'b1;
        wait_grant("pol");
        chk("pol_gch", int'(bus.grant_ch), 2);
        chk("pol_dack", int'(bus.dack), 4'b1011);

        // Masking mid-grant keeps the grant; dropping hlda aborts it.
        bus.mask = 4'b0100;
        step(2);
        chk("mask_keep_gv", int'(bus.grant_valid), 1);
        chk("mask_keep_gch", int'(bus.grant_ch), 2);
        bus.hlda = 1'b0;
        step(1);
        chk("abort_gv", int'(bus.grant_valid), 0);
        chk("abort_hrq", int'(bus.hrq), 0);
        chk("abort_dack", int'(bus.dack), 4'hF);
        bus.mask = 4'b0000;
        bus.dreq_low = 1'b0;
        bus.dack_low = 1'b0;
        bus.dreq = 4'b0011;
        bus.hlda = 1'b1;
        wait_grant("abort_ptr");
        chk("abort_ptr_kept", int'(bus.grant_ch), 1);

        // Reset during a grant returns ptr to 0.
        bus.xfer_done = 1'b1;
        bus.dreq = 4'b1011;
        step(1);
        bus.xfer_done = 1'b0;
        wait_grant("ptr2");
        chk("ptr2_gch", int'(bus.grant_ch), 3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bus.dreq = 4'b1010;
        chk("rstg_hrq", int'(bus.hrq), 0);
        chk("rstg_gv", int'(bus.grant_valid), 0);
        chk("rstg_dack", int'(bus.dack), 0);
        wait_grant("rstg");
        chk("rstg_ptr0", int'(bus.grant_ch), 1);
        bus.dreq = 4'b0000;
        bus.xfer_done = 1'b1;
        step(1);
        bus.xfer_done = 1'b0;
        bus.hlda = 1'b0;
        step(2);

        // Randomized traffic, checked every cycle by the model.
        repeat (3000) begin
            bus.dreq = N'($urandom);
            bus.sw_req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            bus.mask = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 49) == 0) bus.rotate_en = ~bus.rotate_en;
            if ($urandom_range(0, 99) == 0) bus.dreq_low = ~bus.dreq_low;
            if ($urandom_range(0, 99) == 0) bus.dack_low = ~bus.dack_low;
            bus.hlda = ($urandom_range(0, 7) != 0);
            bus.xfer_done = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
